// File: rtl/mips25_mem_pkg.sv
// Shared types and defaults for the memory responder.
package mips25_mem_pkg;

   localparam int unsigned DEF_LATENCY = 2;
   localparam int unsigned DEF_DEPTH   = 256;
   localparam int unsigned CNT_W       = 3;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DONE,
      HOLD
   } state_t;

   typedef enum logic {
      REQ_READ,
      REQ_WRITE
   } req_t;

endpackage

// File: rtl/mem_responder_if.sv
// Control-unit side bus of the memory responder.
interface mem_responder_if;

   logic       ReadEn;
   logic       WriteEn;
   logic [7:0] Adr;
   logic [7:0] WD;
   logic       PreWr;
   logic [7:0] PreAdr;
   logic [7:0] PreData;
   logic [7:0] RD;
   logic       MemReady;
   logic       Busy;
   logic       ErrBar;
   logic [7:0] AccCount;

   modport master (
      output ReadEn, WriteEn, Adr, WD, PreWr, PreAdr, PreData,
      input  RD, MemReady, Busy, ErrBar, AccCount
   );

   modport slave (
      input  ReadEn, WriteEn, Adr, WD, PreWr, PreAdr, PreData,
      output RD, MemReady, Busy, ErrBar, AccCount
   );

endinterface

// File: rtl/mem_array_8b.sv
// Byte-wide storage: one synchronous write port, one registered read port.
// Contents are never reset; only the read register is.
module mem_array_8b #(
   parameter int unsigned DEPTH = 256,
   parameter int unsigned AW    = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [7:0]    wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [7:0]    rdata
);

   logic [7:0] mem [DEPTH];

   // Write port.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Read register; holds its value until the next read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/mem_responder.sv
// Memory responder: accepts one read or write strobe in IDLE, waits LATENCY
// cycles, performs the access, pulses MemReady, then waits for the strobes
// to drop before accepting again.
module mem_responder
   import mips25_mem_pkg::*;
#(
   parameter int unsigned LATENCY = DEF_LATENCY,
   parameter int unsigned DEPTH   = DEF_DEPTH
) (
   input  logic           Fclk,
   input  logic           ResetBar,
   mem_responder_if.slave bus
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   // Addresses wrap modulo DEPTH.
   function automatic logic [AW-1:0] idx_of(input logic [7:0] a);
      return AW'(32'(a) % DEPTH);
   endfunction

   state_t           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [7:0]       lat_adr, adr_n;
   logic [7:0]       lat_wd, wd_n;
   req_t             lat_kind, kind_n;
   logic             rdy_q, rdy_n;
   logic             busy_q, busy_n;
   logic             err_q, err_n;
   logic [7:0]       acc_q, acc_n;

   logic             mem_we, mem_re, wr_en;
   logic [AW-1:0]    mem_waddr;
   logic [7:0]       mem_wdata;
   logic [7:0]       rd_q;

   // Next-state, latch, counter and memory-port control.
   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      adr_n     = lat_adr;
      wd_n      = lat_wd;
      kind_n    = lat_kind;
      rdy_n     = 1'b0;
      err_n     = err_q;
      acc_n     = acc_q;
      mem_we    = 1'b0;
      mem_re    = 1'b0;
      mem_waddr = idx_of(lat_adr);
      mem_wdata = lat_wd;
      case (state)
         IDLE: begin
            if (bus.ReadEn != bus.WriteEn) begin
               state_n = WAIT;
               cnt_n   = CNT_W'(LATENCY);
               adr_n   = bus.Adr;
               wd_n    = bus.WD;
               kind_n  = bus.WriteEn ? REQ_WRITE : REQ_READ;
            end else if (bus.ReadEn) begin
               err_n = 1'b0;
            end else if (bus.PreWr) begin
               mem_we    = 1'b1;
               mem_waddr = idx_of(bus.PreAdr);
               mem_wdata = bus.PreData;
            end
         end
         WAIT: begin
            if (cnt != '0) begin
               cnt_n = cnt - 1'b1;
            end else begin
               state_n = DONE;
               rdy_n   = 1'b1;
               acc_n   = acc_q + 8'd1;
               if (lat_kind == REQ_WRITE) begin
                  mem_we = 1'b1;
               end else begin
                  mem_re = 1'b1;
               end
            end
         end
         DONE: begin
            state_n = HOLD;
         end
         HOLD: begin
            if (!bus.ReadEn && !bus.WriteEn) begin
               state_n = IDLE;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
      busy_n = (state_n == WAIT) || (state_n == DONE);
   end

   // State and registered outputs.
   always_ff @(posedge Fclk or negedge ResetBar) begin
      if (!ResetBar) begin
         state    <= IDLE;
         cnt      <= '0;
         lat_adr  <= '0;
         lat_wd   <= '0;
         lat_kind <= REQ_READ;
         rdy_q    <= 1'b0;
         busy_q   <= 1'b0;
         err_q    <= 1'b1;
         acc_q    <= '0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         lat_adr  <= adr_n;
         lat_wd   <= wd_n;
         lat_kind <= kind_n;
         rdy_q    <= rdy_n;
         busy_q   <= busy_n;
         err_q    <= err_n;
         acc_q    <= acc_n;
      end
   end

   // Write port is gated so nothing lands in memory while reset is held.
   assign wr_en = mem_we & ResetBar;

   mem_array_8b #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_array (
      .clk   (Fclk),
      .rst_n (ResetBar),
      .we    (wr_en),
      .waddr (mem_waddr),
      .wdata (mem_wdata),
      .re    (mem_re),
      .raddr (idx_of(lat_adr)),
      .rdata (rd_q)
   );

   assign bus.RD       = rd_q;
   assign bus.MemReady = rdy_q;
   assign bus.Busy     = busy_q;
   assign bus.ErrBar   = err_q;
   assign bus.AccCount = acc_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: instance A (LATENCY=2, DEPTH=256) and
// instance B (LATENCY=0, DEPTH=64), checked against a byte-array model.
module tb_mem_responder;

   localparam int unsigned LAT_A   = 2;
   localparam int unsigned DEPTH_A = 256;
   localparam int unsigned LAT_B   = 0;
   localparam int unsigned DEPTH_B = 64;

   logic Fclk = 1'b0;
   logic rst_a, rst_b;
   int   total = 0;
   int   bad   = 0;

   mem_responder_if ba ();
   mem_responder_if bb ();

   mem_responder #(.LATENCY(LAT_A), .DEPTH(DEPTH_A)) dut_a (
      .Fclk     (Fclk),
      .ResetBar (rst_a),
      .bus      (ba)
   );

   mem_responder #(.LATENCY(LAT_B), .DEPTH(DEPTH_B)) dut_b (
      .Fclk     (Fclk),
      .ResetBar (rst_b),
      .bus      (bb)
   );

   always #5 Fclk = ~Fclk;

   // Reference model: instance 0 = A, 1 = B.
   logic [7:0]  ref_mem [2][256];
   logic [7:0]  exp_rd  [2];
   logic [7:0]  exp_acc [2];
   logic        exp_err [2];
   int unsigned lat     [2] = '{LAT_A, LAT_B};
   int unsigned depth   [2] = '{DEPTH_A, DEPTH_B};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] widx(input bit inst, input logic [7:0] a);
      return 8'(32'(a) % depth[inst]);
   endfunction

   function automatic logic [7:0] rd_of(input bit inst);
      return inst ? bb.RD : ba.RD;
   endfunction
   function automatic logic rdy_of(input bit inst);
      return inst ? bb.MemReady : ba.MemReady;
   endfunction
   function automatic logic busy_of(input bit inst);
      return inst ? bb.Busy : ba.Busy;
   endfunction
   function automatic logic err_of(input bit inst);
      return inst ? bb.ErrBar : ba.ErrBar;
   endfunction
   function automatic logic [7:0] acc_of(input bit inst);
      return inst ? bb.AccCount : ba.AccCount;
   endfunction

   task automatic drive(input bit inst, input logic re, input logic we,
                        input logic [7:0] a, input logic [7:0] d);
      if (inst) begin
         bb.ReadEn = re; bb.WriteEn = we; bb.Adr = a; bb.WD = d;
      end else begin
         ba.ReadEn = re; ba.WriteEn = we; ba.Adr = a; ba.WD = d;
      end
   endtask

   task automatic set_pre(input bit inst, input logic en, input logic [7:0] a, input logic [7:0] d);
      if (inst) begin
         bb.PreWr = en; bb.PreAdr = a; bb.PreData = d;
      end else begin
         ba.PreWr = en; ba.PreAdr = a; ba.PreData = d;
      end
   endtask

   task automatic preload(input bit inst, input logic [7:0] a, input logic [7:0] d);
      @(negedge Fclk);
      set_pre(inst, 1'b1, a, d);
      @(negedge Fclk);
      set_pre(inst, 1'b0, 8'h00, 8'h00);
      ref_mem[inst][widx(inst, a)] = d;
   endtask

   // One complete access; strobe drops right after acceptance, and Adr/WD
   // are scrambled while the access is in flight. Optional preload driven
   // on the accepting edge must be dropped.
   task automatic access(input bit inst, input bit wr, input logic [7:0] a, input logic [7:0] d,
                         input bit pre_en, input logic [7:0] pre_a, input logic [7:0] pre_d);
      int rdy_at = -1;
      int pulses = 0;
      int busy   = 0;
      int l      = int'(lat[inst]);
      @(negedge Fclk);
      drive(inst, !wr, wr, a, d);
      if (pre_en) set_pre(inst, 1'b1, pre_a, pre_d);
      for (int n = 0; n < l + 6; n++) begin
         @(negedge Fclk);
         if (n == 0) begin
            drive(inst, 1'b0, 1'b0, 8'($urandom), 8'($urandom));
            set_pre(inst, 1'b0, 8'h00, 8'h00);
         end
         if (rdy_of(inst)) begin
            pulses++;
            if (rdy_at < 0) rdy_at = n;
         end
         if (busy_of(inst)) busy++;
         if (n == l) check("rd_before_done", rd_of(inst), exp_rd[inst]);
      end
      if (wr) ref_mem[inst][widx(inst, a)] = d;
      else    exp_rd[inst] = ref_mem[inst][widx(inst, a)];
      exp_acc[inst] = exp_acc[inst] + 8'd1;
      check("ready_latency", rdy_at, l + 1);
      check("ready_pulses", pulses, 1);
      check("busy_cycles", busy, l + 2);
      check("rd", rd_of(inst), exp_rd[inst]);
      check("acc_count", acc_of(inst), exp_acc[inst]);
      check("err_bar", err_of(inst), exp_err[inst]);
   endtask

   task automatic check_reset(input bit inst);
      check("rst_rd", rd_of(inst), 8'h00);
      check("rst_ready", rdy_of(inst), 1'b0);
      check("rst_busy", busy_of(inst), 1'b0);
      check("rst_err", err_of(inst), 1'b1);
      check("rst_acc", acc_of(inst), 8'h00);
      exp_rd[inst]  = 8'h00;
      exp_acc[inst] = 8'h00;
      exp_err[inst] = 1'b1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got no end of test expected end of test before time limit");
      $fatal(1, "time limit");
   end

   initial begin
      int pulses;
      int busy;
      logic [7:0] v;
      drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
      set_pre(1'b0, 1'b0, 8'h00, 8'h00);
      set_pre(1'b1, 1'b0, 8'h00, 8'h00);
      rst_a = 1'b0;
      rst_b = 1'b0;
      repeat (3) @(negedge Fclk);
      check_reset(1'b0);
      check_reset(1'b1);
      rst_a = 1'b1;
      rst_b = 1'b1;

      // Fill A completely so every address has a known value.
      for (int i = 0; i < 256; i++) preload(1'b0, 8'(i), 8'($urandom));
      preload(1'b0, 8'h10, 8'hA5);
      preload(1'b0, 8'h30, 8'h11);

      // Read of preloaded 0x10, then write/read of 0x20.
      access(1'b0, 1'b0, 8'h10, 8'h00, 1'b0, 8'h00, 8'h00);
      check("first_read_a5", ba.RD, 8'hA5);
      access(1'b0, 1'b1, 8'h20, 8'h3C, 1'b0, 8'h00, 8'h00);
      check("write_count", ba.AccCount, 8'd2);
      access(1'b0, 1'b0, 8'h20, 8'h00, 1'b0, 8'h00, 8'h00);
      check("readback_3c", ba.RD, 8'h3C);

      // A strobe on the same edge as PreWr wins; the preload is dropped.
      v = ~ref_mem[0][8'h41];
      access(1'b0, 1'b0, 8'h40, 8'h00, 1'b1, 8'h41, v);
      access(1'b0, 1'b0, 8'h41, 8'h00, 1'b0, 8'h00, 8'h00);

      // Random mix of reads and writes.
      for (int i = 0; i < 40; i++) begin
         access(1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'b0, 8'h00, 8'h00);
      end

      // Strobe held high is served once; re-raised strobe is served again.
      @(negedge Fclk);
      drive(1'b0, 1'b1, 1'b0, 8'h10, 8'h00);
      pulses = 0;
      for (int n = 0; n < 10; n++) begin
         @(negedge Fclk);
         if (ba.MemReady) pulses++;
      end
      check("held_pulses", pulses, 1);
      drive(1'b0, 1'b0, 1'b0, 8'h10, 8'h00);
      pulses = 0;
      for (int n = 0; n < 3; n++) begin
         @(negedge Fclk);
         if (ba.MemReady) pulses++;
      end
      check("dropped_pulses", pulses, 0);
      drive(1'b0, 1'b1, 1'b0, 8'h10, 8'h00);
      for (int n = 0; n < 6; n++) begin
         @(negedge Fclk);
         if (ba.MemReady) pulses++;
      end
      drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      repeat (3) @(negedge Fclk);
      check("reraised_pulses", pulses, 1);
      exp_acc[0] = exp_acc[0] + 8'd2;
      exp_rd[0]  = ref_mem[0][8'h10];
      check("held_acc", ba.AccCount, exp_acc[0]);
      check("held_rd", ba.RD, exp_rd[0]);

      // Both strobes in IDLE: protocol error, no access.
      @(negedge Fclk);
      drive(1'b0, 1'b1, 1'b1, 8'h20, 8'hFF);
      pulses = 0;
      busy   = 0;
      for (int n = 0; n < 3; n++) begin
         @(negedge Fclk);
         if (ba.MemReady) pulses++;
         if (ba.Busy) busy++;
      end
      check("both_err", ba.ErrBar, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      repeat (2) @(negedge Fclk);
      exp_err[0] = 1'b0;
      check("both_err_sticky", ba.ErrBar, 1'b0);
      check("both_pulses", pulses, 0);
      check("both_busy", busy, 0);
      check("both_acc", ba.AccCount, exp_acc[0]);
      access(1'b0, 1'b0, 8'h20, 8'h00, 1'b0, 8'h00, 8'h00);
      @(negedge Fclk);
      rst_a = 1'b0;
      #1;
      check_reset(1'b0);
      @(negedge Fclk);
      rst_a = 1'b1;
      @(negedge Fclk);
      check("err_after_reset", ba.ErrBar, 1'b1);

      // Reset during WAIT of a write abandons the write.
      preload(1'b0, 8'h30, 8'h11);
      @(negedge Fclk);
      drive(1'b0, 1'b0, 1'b1, 8'h30, 8'h5A);
      @(negedge Fclk);
      drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      check("wait_busy", ba.Busy, 1'b1);
      #2;
      rst_a = 1'b0;
      #1;
      check_reset(1'b0);
      repeat (2) @(negedge Fclk);
      rst_a = 1'b1;
      access(1'b0, 1'b0, 8'h30, 8'h00, 1'b0, 8'h00, 8'h00);
      check("abandoned_write", ba.RD, 8'h11);

      // B: zero latency, 64-byte array with address wrap, 256 reads.
      for (int i = 0; i < 64; i++) begin
         preload(1'b1, 8'(i + 64 * int'($urandom_range(0, 3))), 8'($urandom));
      end
      for (int i = 0; i < 256; i++) begin
         access(1'b1, 1'b0, 8'($urandom), 8'h00, 1'b0, 8'h00, 8'h00);
      end
      check("b_acc_wrap", bb.AccCount, 8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
